// File: rtl/uart_pkt_tx_if.sv
// Packet handshake between a producer and the UART packet transmitter.
// The producer holds pkt_data/pkt_valid until it sees pkt_ready.
interface uart_pkt_tx_if #(
  parameter int DATA_BITS = 8,
  parameter int NUM_BYTES = 3
);
  logic [NUM_BYTES*DATA_BITS-1:0] pkt_data;
  logic                           pkt_valid;
  logic                           pkt_ready;

  modport master (output pkt_data, output pkt_valid, input pkt_ready);
  modport slave  (input pkt_data, input pkt_valid, output pkt_ready);
endinterface

// File: rtl/uart_pkt_tx.sv
// Serialises a NUM_BYTES packet as back-to-back UART characters:
// start, LSB-first data, optional parity, STOP_BITS stop bits.
module uart_pkt_tx #(
  parameter int DATA_BITS  = 8,
  parameter int NUM_BYTES  = 3,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         baud_tick,
  uart_pkt_tx_if.slave pkt,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, ARMED, START, DATA, PARITY, STOP} state_t;

  state_t                             state, state_d;
  logic [NUM_BYTES-1:0][DATA_BITS-1:0] pkt_buf, pkt_buf_d;
  logic [CW-1:0]                      char_cnt, char_cnt_d;
  logic [BW-1:0]                      bit_cnt, bit_cnt_d, bit_nxt;
  logic                               stop_cnt, stop_cnt_d;
  logic                               tx_d, done_d;
  logic [DATA_BITS-1:0]               cur_char;
  logic                               last_bit, last_stop, last_char, parity_bit;

  assign cur_char   = pkt_buf[char_cnt];
  assign bit_nxt    = bit_cnt + 1'b1;
  assign last_bit   = (bit_cnt == BW'(DATA_BITS-1));
  assign last_char  = (char_cnt == CW'(NUM_BYTES-1));
  assign last_stop  = (STOP_BITS == 1) ? 1'b1 : stop_cnt;
  assign parity_bit = (^cur_char) ^ (PARITY_ODD != 0);

  assign busy          = (state != IDLE);
  assign pkt.pkt_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pkt_buf  <= '0;
      char_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      pkt_buf  <= pkt_buf_d;
      char_cnt <= char_cnt_d;
      bit_cnt  <= bit_cnt_d;
      stop_cnt <= stop_cnt_d;
      tx       <= tx_d;
      done     <= done_d;
    end
  end

  // tx is registered: each branch sets the line level for the bit the
  // next state represents, so state and line change on the same tick.
  always_comb begin
    state_d    = state;
    pkt_buf_d  = pkt_buf;
    char_cnt_d = char_cnt;
    bit_cnt_d  = bit_cnt;
    stop_cnt_d = stop_cnt;
    tx_d       = tx;
    done_d     = 1'b0;
    case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (pkt.pkt_valid) begin
          pkt_buf_d  = pkt.pkt_data;
          char_cnt_d = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          state_d    = ARMED;
        end
      end
      // entered after the acceptance edge, so a tick in that cycle never counts
      ARMED: begin
        if (baud_tick) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_tick) begin
          tx_d      = cur_char[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (last_bit) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              tx_d    = parity_bit;
              state_d = PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = STOP;
            end
          end else begin
            bit_cnt_d = bit_nxt;
            tx_d      = cur_char[bit_nxt];
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (!last_stop) begin
            stop_cnt_d = 1'b1;
          end else if (last_char) begin
            tx_d       = 1'b1;
            char_cnt_d = '0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else begin
            // next start bit on the same tick: no gap between characters
            char_cnt_d = char_cnt + 1'b1;
            stop_cnt_d = 1'b0;
            tx_d       = 1'b0;
            state_d    = START;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_pkt_tx.sv
// Bench for uart_pkt_tx: four parameter variants, a line-bit scoreboard,
// a vector table plus back-to-back and mid-packet reset sequences.
`timescale 1ns/1ps
module tb_uart_pkt_tx;
  localparam int NINST = 4;

  logic clk = 1'b0;
  logic rst;
  logic baud_tick;
  always #5 clk = ~clk;

  logic [23:0]      data_v [NINST];
  logic [NINST-1:0] valid_v;
  logic [NINST-1:0] ready_v, tx_v, busy_v, done_v;

  // 0: defaults; 1: even parity, 1 char; 2: odd parity, 1 char; 3: 2 stop bits, 7-bit chars, 2 chars
  for (genvar g = 0; g < NINST; g++) begin : g_dut
    localparam int NB = (g == 0) ? 3 : (g == 3) ? 2 : 1;
    localparam int DB = (g == 3) ? 7 : 8;
    localparam int PE = (g == 1 || g == 2) ? 1 : 0;
    localparam int PO = (g == 2) ? 1 : 0;
    localparam int SB = (g == 3) ? 2 : 1;
    uart_pkt_tx_if #(.DATA_BITS(DB), .NUM_BYTES(NB)) bus ();
    assign bus.pkt_data  = data_v[g][NB*DB-1:0];
    assign bus.pkt_valid = valid_v[g];
    assign ready_v[g]    = bus.pkt_ready;
    uart_pkt_tx #(.DATA_BITS(DB), .NUM_BYTES(NB), .PARITY_EN(PE), .PARITY_ODD(PO), .STOP_BITS(SB)) dut (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .pkt(bus),
      .tx(tx_v[g]), .busy(busy_v[g]), .done(done_v[g]));
  end

  typedef struct packed { logic b; logic last; } exp_t;
  typedef struct { int inst; logic [23:0] data; logic [31:0] bits; int nbits; bit on_tick; int period; } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t tbl [7];
  int   checks = 0, errors = 0;
  int   cur = 0;
  int   tick_period = 4, tick_cnt = 0;
  logic tick_s, busy_s, rst_s, popped_last;

  // baud strobe, updated on the falling edge
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_cnt++;
      baud_tick = ((tick_cnt % tick_period) == 0);
    end
  end

  // scoreboard: every tick seen while busy yields the next expected line level
  initial begin
    forever begin
      @(posedge clk);
      tick_s = baud_tick; busy_s = busy_v[cur]; rst_s = rst;
      #1;
      popped_last = 1'b0;
      if (tick_s && busy_s && !rst_s) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL line_bit: unexpected line activity on inst %0d, tx=%0b, expected none", cur, tx_v[cur]);
        end else begin
          mon_e = exp_q.pop_front();
          if (tx_v[cur] !== mon_e.b) begin
            errors++;
            $display("FAIL line_bit: inst %0d tx=%0b expected %0b (%0d bits left)", cur, tx_v[cur], mon_e.b, exp_q.size());
          end
          checks++;
          if (done_v[cur] !== mon_e.last) begin
            errors++;
            $display("FAIL done_pulse: inst %0d done=%0b expected %0b", cur, done_v[cur], mon_e.last);
          end
          popped_last = mon_e.last;
        end
      end
      if (done_v[cur] === 1'b1 && !popped_last) begin
        checks++; errors++;
        $display("FAIL stray_done: inst %0d done=1 expected 0", cur);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) exp_q.push_back('{b: bits[i], last: 1'b0});
    exp_q.push_back('{b: 1'b1, last: 1'b1});
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_in_time", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v, input bit drain);
    int guard;
    cur = v.inst;
    tick_period = v.period;
    guard = 0;
    do begin
      @(negedge clk); #1;
      guard++;
    end while ((baud_tick != v.on_tick) && guard < 20);
    chk("ready_before_accept", ready_v[v.inst], 1);
    data_v[v.inst]  = v.data;
    valid_v[v.inst] = 1'b1;
    push_frame(v.bits, v.nbits);
    @(posedge clk); #1;
    chk("tx_idle_after_accept", tx_v[v.inst], 1);
    chk("busy_after_accept", busy_v[v.inst], 1);
    valid_v[v.inst] = 1'b0;
    data_v[v.inst]  = 24'($urandom);
    if (drain) wait_drain(v.nbits * v.period * 2 + 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{0, 24'h5A12A5, 32'h2B48934A, 30, 1'b0, 4};
    tbl[1] = '{1, 24'h000007, 32'h0000060E, 11, 1'b0, 4};
    tbl[2] = '{2, 24'h000007, 32'h0000040E, 11, 1'b0, 3};
    tbl[3] = '{3, 24'h0007D5, 32'h000C7BAA, 20, 1'b0, 4};
    tbl[4] = '{0, 24'h5A12A5, 32'h2B48934A, 30, 1'b1, 5};
    tbl[5] = '{0, 24'h000000, 32'h20080200, 30, 1'b0, 2};
    tbl[6] = '{0, 24'hFFFFFF, 32'h3FEFFBFE, 30, 1'b1, 1};

    rst = 1'b1;
    valid_v = '0;
    for (int i = 0; i < NINST; i++) data_v[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NINST; i++) begin
      chk("reset_tx", tx_v[i], 1);
      chk("reset_busy", busy_v[i], 0);
      chk("reset_done", done_v[i], 0);
      chk("reset_ready", ready_v[i], 1);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(tbl[i], 1'b1);

    // back-to-back: valid held high, second packet taken in the done cycle
    cur = 0; tick_period = 4;
    @(negedge clk); #1;
    data_v[0] = 24'h5A12A5; valid_v[0] = 1'b1;
    push_frame(32'h2B48934A, 30);
    @(posedge clk); #1;
    data_v[0] = 24'h000000;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (done_v[0] !== 1'b1 && n < 400);
    chk("b2b_done_seen", done_v[0], 1);
    chk("b2b_ready_in_done", ready_v[0], 1);
    push_frame(32'h20080200, 30);
    @(posedge clk); #1;
    chk("b2b_accepted", busy_v[0], 1);
    valid_v[0] = 1'b0;
    wait_drain(300);

    // reset while character 1 bit 4 is on the line
    run_vec(tbl[0], 1'b0);
    n = 0;
    while (exp_q.size() != 15 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk("reset_point_reached", exp_q.size(), 15);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    chk("midrst_tx", tx_v[0], 1);
    chk("midrst_busy", busy_v[0], 0);
    chk("midrst_ready", ready_v[0], 1);
    chk("midrst_done", done_v[0], 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("idle_ignores_tick_tx", tx_v[0], 1);
    chk("idle_ignores_tick_busy", busy_v[0], 0);
    run_vec(tbl[0], 1'b1);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
